// File: rtl/trig_phase_framer.sv
// rtl/trig_phase_framer.sv - trigger-phase byte stream framer with timestamped record FIFO
//
// Locks onto the 32-bit idle-word framing of an 8-bit clk160 byte stream,
// decodes trigger frames (bytes 0..2 zero) into bit-reversed phase values,
// stamps each with the frame count since lock and queues {timestamp, phase}
// in a first-word-fall-through FIFO.
//
// Ports:
//   clk160       sole clock, rising edge
//   reset        synchronous, active-high
//   rx_byte      stream byte, one per cycle, LSB byte of each frame first
//   m_valid      FIFO head holds a record
//   m_ready      consumer pops the head when m_valid && m_ready
//   m_phase      head record phase
//   m_timestamp  head record frame count
//   locked       framer is in LOCKED state
//   trig_count   triggers decoded while locked (wraps)
//   drop_count   triggers lost to a full FIFO (saturates)
//   err_count    error frames while locked (saturates)
module trig_phase_framer #(
    parameter logic [31:0] IDLE_WORD     = 32'h33333335,
    parameter int          LOCK_FRAMES   = 4,
    parameter int          UNLOCK_FRAMES = 4,
    parameter int          FIFO_AW       = 4
) (
    input  logic        clk160,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_phase,
    output logic [31:0] m_timestamp,
    output logic        locked,
    output logic [31:0] trig_count,
    output logic [15:0] drop_count,
    output logic [15:0] err_count
);

    localparam int         DEPTH    = 1 << FIFO_AW;
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  rb_q;
    logic [1:0]  bpos_q;
    logic [3:0]  good_q;
    logic [3:0]  errrun_q;
    logic [7:0]  byte0_q, byte1_q, byte2_q;
    logic [31:0] ts_q;
    logic        locked_q;
    logic [31:0] trig_q;
    logic [15:0] drop_q;
    logic [15:0] err_q;

    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   fifo_cnt_q;
    logic [39:0]        mem [DEPTH];

    logic [7:0]  idle_byte;
    logic [3:0]  good_d;
    logic [3:0]  errrun_d;
    logic        frame_end;
    logic        frame_idle;
    logic        frame_trig;
    logic [7:0]  phase;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [39:0] head;

    // Expected idle byte for the current position while verifying framing.
    always_comb begin
        idle_byte = IDLE_WORD[7:0];
        case (bpos_q)
            2'd0: idle_byte = IDLE_WORD[7:0];
            2'd1: idle_byte = IDLE_WORD[15:8];
            2'd2: idle_byte = IDLE_WORD[23:16];
            2'd3: idle_byte = IDLE_WORD[31:24];
            default: idle_byte = IDLE_WORD[7:0];
        endcase
    end

    always_comb begin
        phase = 8'h00;
        for (int i = 0; i < 8; i++) begin
            phase[i] = rb_q[7-i];
        end
    end

    assign good_d     = good_q + 4'd1;
    assign errrun_d   = errrun_q + 4'd1;
    // The frame is classified when its last byte sits in rb.
    assign frame_end  = (state_q == ST_LOCKED) && (bpos_q == 2'd3);
    assign frame_idle = ({rb_q, byte2_q, byte1_q, byte0_q} == IDLE_WORD);
    assign frame_trig = !frame_idle && (byte0_q == 8'h00) && (byte1_q == 8'h00)
                        && (byte2_q == 8'h00);

    // Full is judged on the registered count, so a same-cycle pop does not
    // make room for the write.
    assign fifo_full  = (fifo_cnt_q == DEPTH[FIFO_AW:0]);
    assign push       = frame_end && frame_trig && !fifo_full;
    assign pop        = m_valid && m_ready;

    assign m_valid     = (fifo_cnt_q != '0);
    assign head        = mem[rd_ptr_q];
    assign m_phase     = m_valid ? head[7:0]  : 8'h00;
    assign m_timestamp = m_valid ? head[39:8] : 32'h0;

    assign locked     = locked_q;
    assign trig_count = trig_q;
    assign drop_count = drop_q;
    assign err_count  = err_q;

    always_ff @(posedge clk160) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            rb_q     <= 8'h00;
            bpos_q   <= 2'd0;
            good_q   <= 4'd0;
            errrun_q <= 4'd0;
            byte0_q  <= 8'h00;
            byte1_q  <= 8'h00;
            byte2_q  <= 8'h00;
            ts_q     <= 32'h0;
            locked_q <= 1'b0;
            trig_q   <= 32'h0;
            drop_q   <= 16'h0;
            err_q    <= 16'h0;
        end else begin
            rb_q <= rx_byte;
            case (state_q)
                ST_HUNT: begin
                    if (rb_q == IDLE_WORD[7:0]) begin
                        bpos_q  <= 2'd1;
                        good_q  <= 4'd0;
                        state_q <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (rb_q == idle_byte) begin
                        bpos_q <= bpos_q + 2'd1;
                        if (bpos_q == 2'd3) begin
                            good_q <= good_d;
                            if (good_d == LOCK_N) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                ts_q     <= 32'h0;
                                errrun_q <= 4'd0;
                            end
                        end
                    end else begin
                        // The mismatching byte is consumed, not re-tested as byte 0.
                        bpos_q  <= 2'd0;
                        state_q <= ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    bpos_q <= bpos_q + 2'd1;
                    case (bpos_q)
                        2'd0: byte0_q <= rb_q;
                        2'd1: byte1_q <= rb_q;
                        2'd2: byte2_q <= rb_q;
                        default: begin
                            ts_q <= ts_q + 32'd1;
                            if (frame_idle) begin
                                errrun_q <= 4'd0;
                            end else if (frame_trig) begin
                                trig_q   <= trig_q + 32'd1;
                                errrun_q <= 4'd0;
                                if (fifo_full && drop_q != 16'hFFFF) begin
                                    drop_q <= drop_q + 16'd1;
                                end
                            end else begin
                                if (err_q != 16'hFFFF) begin
                                    err_q <= err_q + 16'd1;
                                end
                                errrun_q <= errrun_d;
                                if (errrun_d == UNLOCK_N) begin
                                    state_q  <= ST_HUNT;
                                    locked_q <= 1'b0;
                                    bpos_q   <= 2'd0;
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    state_q  <= ST_HUNT;
                    locked_q <= 1'b0;
                    bpos_q   <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk160) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    // Storage array carries no reset; outputs are gated by m_valid instead.
    always_ff @(posedge clk160) begin
        if (push) begin
            mem[wr_ptr_q] <= {ts_q, phase};
        end
    end

endmodule

// File: tb/tb_trig_phase_framer.sv
// tb/tb_trig_phase_framer.sv - directed self-checking bench for trig_phase_framer
module tb_trig_phase_framer;

    logic        clk160;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_phase;
    logic [31:0] m_timestamp;
    logic        locked;
    logic [31:0] trig_count;
    logic [15:0] drop_count;
    logic [15:0] err_count;

    int pass_cnt;
    int total_cnt;
    int ipos;
    logic [31:0] idle_w;

    trig_phase_framer dut (
        .clk160      (clk160),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_phase     (m_phase),
        .m_timestamp (m_timestamp),
        .locked      (locked),
        .trig_count  (trig_count),
        .drop_count  (drop_count),
        .err_count   (err_count)
    );

    initial clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        @(posedge clk160);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic send_idle_byte();
        send_byte(idle_w[ipos*8 +: 8]);
        ipos = (ipos + 1) % 4;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rx_byte = 8'h00;
        m_ready = 1'b0;
        @(posedge clk160);
        #1;
        reset = 1'b0;
        ipos  = 0;
    endtask

    task automatic lock_up();
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'h35, 8'h33, 8'h33, 8'h33);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%0h want=0", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'h00) $display("FAIL reset_m_phase got=%0h want=0", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'h0) $display("FAIL reset_m_timestamp got=%0h want=0", m_timestamp); else pass_cnt++;
        total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got=%0h want=0", locked); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'h0) $display("FAIL reset_trig_count got=%0h want=0", trig_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL reset_drop_count got=%0h want=0", drop_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'h0) $display("FAIL reset_err_count got=%0h want=0", err_count); else pass_cnt++;
    endtask

    task automatic test_lock();
        do_reset();
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        total_cnt++; if (locked !== 1'b0) $display("FAIL lock_early got=%0h want=0", locked); else pass_cnt++;
        send_byte(8'h35);
        total_cnt++; if (locked !== 1'b1) $display("FAIL lock_rise got=%0h want=1", locked); else pass_cnt++;
        send_frame(8'h33, 8'h33, 8'h33, 8'h35);
        total_cnt++; if (trig_count !== 32'h0) $display("FAIL lock_trig_count got=%0h want=0", trig_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'h0) $display("FAIL lock_err_count got=%0h want=0", err_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL lock_drop_count got=%0h want=0", drop_count); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL lock_m_valid got=%0h want=0", m_valid); else pass_cnt++;
    endtask

    task automatic test_trigger();
        lock_up();
        send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        send_frame(8'h00, 8'h00, 8'h00, 8'h0B);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL trig_valid_early got=%0h want=0", m_valid); else pass_cnt++;
        send_byte(8'h35);
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL trig_valid got=%0h want=1", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'hD0) $display("FAIL trig_phase got=%0h want=d0", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'd2) $display("FAIL trig_ts got=%0d want=2", m_timestamp); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'd1) $display("FAIL trig_count got=%0d want=1", trig_count); else pass_cnt++;
        m_ready = 1'b1;
        send_byte(8'h33);
        m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL trig_pop_empty got=%0h want=0", m_valid); else pass_cnt++;
        send_byte(8'h33);
        send_byte(8'h33);
    endtask

    task automatic test_backpressure();
        lock_up();
        for (int i = 0; i < 20; i++) send_frame(8'h00, 8'h00, 8'h00, 8'(i + 1));
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        total_cnt++; if (drop_count !== 16'd4) $display("FAIL bp_drop_count got=%0d want=4", drop_count); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'd20) $display("FAIL bp_trig_count got=%0d want=20", trig_count); else pass_cnt++;
        total_cnt++; if (m_phase !== rev8(8'd1)) $display("FAIL bp_head0_phase got=%0h want=%0h", m_phase, rev8(8'd1)); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'd0) $display("FAIL bp_head0_ts got=%0d want=0", m_timestamp); else pass_cnt++;
        send_byte(8'hFF);
        // Classification edge of a trigger while full, with a simultaneous pop.
        m_ready = 1'b1;
        ipos = 0;
        send_idle_byte();
        m_ready = 1'b0;
        total_cnt++; if (drop_count !== 16'd5) $display("FAIL bp_drop_on_pop got=%0d want=5", drop_count); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'd21) $display("FAIL bp_trig_count2 got=%0d want=21", trig_count); else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d] got=%0h want=1", i, m_valid); else pass_cnt++;
            total_cnt++; if (m_phase !== rev8(8'(i + 1))) $display("FAIL bp_drain_phase[%0d] got=%0h want=%0h", i, m_phase, rev8(8'(i + 1))); else pass_cnt++;
            total_cnt++; if (m_timestamp !== 32'(i)) $display("FAIL bp_drain_ts[%0d] got=%0d want=%0d", i, m_timestamp, i); else pass_cnt++;
            m_ready = 1'b1;
            send_idle_byte();
            m_ready = 1'b0;
        end
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_drained got=%0h want=0", m_valid); else pass_cnt++;
        while (ipos != 0) send_idle_byte();
    endtask

    task automatic test_unlock();
        lock_up();
        send_frame(8'h00, 8'h00, 8'h00, 8'h80);
        for (int i = 0; i < 3; i++) send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        for (int i = 0; i < 4; i++) send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        total_cnt++; if (locked !== 1'b1) $display("FAIL unlock_early got=%0h want=1", locked); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd6) $display("FAIL unlock_err6 got=%0d want=6", err_count); else pass_cnt++;
        send_byte(8'h35);
        total_cnt++; if (locked !== 1'b0) $display("FAIL unlock_fall got=%0h want=0", locked); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd7) $display("FAIL unlock_err7 got=%0d want=7", err_count); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL unlock_rec_valid got=%0h want=1", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'h01) $display("FAIL unlock_rec_phase got=%0h want=01", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'd0) $display("FAIL unlock_rec_ts got=%0d want=0", m_timestamp); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'd1) $display("FAIL unlock_trig_count got=%0d want=1", trig_count); else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_reset();
        send_byte(8'h33);
        send_byte(8'h33);
        send_byte(8'h35);
        send_byte(8'h00);
        send_byte(8'h33);
        send_byte(8'h33);
        for (int i = 0; i < 4; i++) send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        total_cnt++; if (locked !== 1'b0) $display("FAIL mis_lock_early got=%0h want=0", locked); else pass_cnt++;
        send_byte(8'h00);
        total_cnt++; if (locked !== 1'b1) $display("FAIL mis_lock got=%0h want=1", locked); else pass_cnt++;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0B);
        send_byte(8'h35);
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL mis_valid got=%0h want=1", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'hD0) $display("FAIL mis_phase got=%0h want=d0", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'd0) $display("FAIL mis_ts got=%0d want=0", m_timestamp); else pass_cnt++;
        send_byte(8'h33);
        send_byte(8'h33);
        send_byte(8'h33);
    endtask

    task automatic test_reset_mid();
        lock_up();
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        send_frame(8'h00, 8'h00, 8'h00, 8'h02);
        send_frame(8'h00, 8'h00, 8'h00, 8'h03);
        send_frame(8'h00, 8'h00, 8'h00, 8'h04);
        send_byte(8'h00);
        total_cnt++; if (trig_count !== 32'd5) $display("FAIL rm_trig5 got=%0d want=5", trig_count); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL rm_valid got=%0h want=1", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'h00) $display("FAIL rm_zero_phase got=%0h want=0", m_phase); else pass_cnt++;
        send_byte(8'h00);
        reset   = 1'b1;
        rx_byte = 8'h00;
        @(posedge clk160);
        #1;
        reset = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rm_m_valid got=%0h want=0", m_valid); else pass_cnt++;
        total_cnt++; if (m_phase !== 8'h00) $display("FAIL rm_m_phase got=%0h want=0", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'h0) $display("FAIL rm_m_ts got=%0h want=0", m_timestamp); else pass_cnt++;
        total_cnt++; if (locked !== 1'b0) $display("FAIL rm_locked got=%0h want=0", locked); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'h0) $display("FAIL rm_trig_count got=%0d want=0", trig_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'h0) $display("FAIL rm_err_count got=%0d want=0", err_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL rm_drop_count got=%0d want=0", drop_count); else pass_cnt++;
        for (int i = 0; i < 4; i++) send_frame(8'h35, 8'h33, 8'h33, 8'h33);
        send_byte(8'h35);
        total_cnt++; if (locked !== 1'b1) $display("FAIL rm_relock got=%0h want=1", locked); else pass_cnt++;
        send_byte(8'h33);
        send_byte(8'h33);
        send_byte(8'h33);
        send_frame(8'h00, 8'h00, 8'h00, 8'h0B);
        send_byte(8'h35);
        total_cnt++; if (m_phase !== 8'hD0) $display("FAIL rm_phase got=%0h want=d0", m_phase); else pass_cnt++;
        total_cnt++; if (m_timestamp !== 32'd1) $display("FAIL rm_ts got=%0d want=1", m_timestamp); else pass_cnt++;
        total_cnt++; if (trig_count !== 32'd1) $display("FAIL rm_trig_count1 got=%0d want=1", trig_count); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        ipos      = 0;
        idle_w    = 32'h33333335;
        reset     = 1'b1;
        rx_byte   = 8'h00;
        m_ready   = 1'b0;
        test_reset();
        test_lock();
        test_trigger();
        test_backpressure();
        test_unlock();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
